// File: rtl/mem_arbiter_if.sv
// Bus bundle between the datapath (imem/dmem ports), the RAM model and
// mem_arbiter. The arbiter connects through the slave modport. The
// environment (datapath plus RAM) drives and observes through the master
// modport.
interface mem_arbiter_if;
    // instruction-fetch side
    logic        iREN;
    logic [31:0] iaddr;
    logic [31:0] iload;
    logic        iwait;

    // data side
    logic        dREN;
    logic        dWEN;
    logic        datomic;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [31:0] dload;
    logic        dwait;

    // single-ported RAM side
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic        ramready;

    // arbiter view
    modport slave (
        input  iREN, iaddr,
        input  dREN, dWEN, datomic, daddr, dstore,
        input  ramload, ramready,
        output iload, iwait,
        output dload, dwait,
        output ramREN, ramWEN, ramaddr, ramstore
    );

    // datapath + RAM view
    modport master (
        output iREN, iaddr,
        output dREN, dWEN, datomic, daddr, dstore,
        output ramload, ramready,
        input  iload, iwait,
        input  dload, dwait,
        input  ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported RAM between the instruction-fetch
// port and the data port.
// - Each access runs IDLE -> IACC/DACC -> DONE -> IDLE.
// - Data requests normally win arbitration. A starvation counter forces a
//   pending fetch through after STARVE_LIMIT consecutive data grants.
// - A watchdog aborts any access that waits TIMEOUT cycles for ramready.
//   An aborted access returns 32'hBAD0BAD0 and sets the sticky err flag.
// Optional feature: define MEM_ARB_LLSC_EN to add load-linked /
// store-conditional tracking (link_valid + link_addr). Without it, datomic
// is ignored and an SC behaves as a plain store.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 64
) (
    input  logic          CLK,
    input  logic          RST,
    mem_arbiter_if.slave  bus,
    output logic          err
);

    // FSM encoding
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_IACC = 2'd1;
    localparam logic [1:0] S_DACC = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // counter widths; each must be at least one bit
    localparam int SW_RAW = $clog2(STARVE_LIMIT + 1);
    localparam int WW_RAW = $clog2(TIMEOUT + 1);
    localparam int SW     = (SW_RAW < 1) ? 1 : SW_RAW;
    localparam int WW     = (WW_RAW < 1) ? 1 : WW_RAW;

    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    // The watchdog fires in the cycle that would take the count to TIMEOUT.
    localparam logic [WW-1:0] WD_LAST    = WW'(TIMEOUT - 1);
    localparam logic [WW-1:0] WD_MAX     = WW'(TIMEOUT);

    localparam logic [31:0] ABORT_WORD = 32'hBAD0_BAD0;

    // registered state
    logic [1:0]    r_state;
    logic [SW-1:0] r_starve_cnt;
    logic [WW-1:0] r_wd_cnt;
    logic          r_err;

    // next-state values
    logic [1:0]    w_state_next;
    logic [SW-1:0] w_starve_next;
    logic [WW-1:0] w_wd_next;
    logic          w_err_next;

    // request decode
    logic w_d_req;     // any data request
    logic w_d_read;    // read only; a write takes precedence
    logic w_d_write;   // write, plain or SC
    logic w_sc_fail;   // SC that must complete without touching RAM
    logic w_wd_fire;   // watchdog expires this cycle

`ifdef MEM_ARB_LLSC_EN
    logic        r_link_valid;
    logic [31:0] r_link_addr;
    logic        w_link_valid_next;
    logic [31:0] w_link_addr_next;
    logic        w_ll;         // load-linked
    logic        w_sc;         // store-conditional
    logic        w_sc_ok;      // SC whose link is still intact
    logic        w_plain_wr;   // non-atomic write
`else
    // datomic has no meaning without link tracking
    logic w_unused_datomic;
    assign w_unused_datomic = bus.datomic;
`endif

    // Decode the data request. The watchdog check is shared by both access states.
    always_comb begin
        w_d_req   = bus.dREN | bus.dWEN;
        w_d_write = bus.dWEN;
        w_d_read  = bus.dREN & ~bus.dWEN;
        w_wd_fire = ~bus.ramready & (r_wd_cnt == WD_LAST);
`ifdef MEM_ARB_LLSC_EN
        w_ll       = bus.datomic & w_d_read;
        w_sc       = bus.datomic & w_d_write;
        w_sc_ok    = w_sc & r_link_valid & (r_link_addr == bus.daddr);
        w_sc_fail  = w_sc & ~w_sc_ok;
        w_plain_wr = w_d_write & ~bus.datomic;
`else
        w_sc_fail  = 1'b0;
`endif
    end

    // FSM next state, counter updates and all combinational bus outputs
    always_comb begin
        w_state_next  = r_state;
        w_starve_next = r_starve_cnt;
        w_wd_next     = r_wd_cnt;
        w_err_next    = r_err;
`ifdef MEM_ARB_LLSC_EN
        w_link_valid_next = r_link_valid;
        w_link_addr_next  = r_link_addr;
`endif
        bus.iload    = 32'd0;
        bus.iwait    = 1'b1;
        bus.dload    = 32'd0;
        bus.dwait    = 1'b1;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = 32'd0;
        bus.ramstore = 32'd0;

        case (r_state)
            S_IDLE: begin
                // The watchdog restarts from zero on every access entry.
                w_wd_next = '0;
                if (bus.iREN && (r_starve_cnt == STARVE_MAX)) begin
                    // The fetch has waited long enough; it beats data.
                    w_state_next  = S_IACC;
                    w_starve_next = '0;
                end else if (w_d_req) begin
                    w_state_next = S_DACC;
                    if (bus.iREN) begin
                        if (r_starve_cnt != STARVE_MAX) begin
                            w_starve_next = r_starve_cnt + 1'b1;
                        end
                    end else begin
                        w_starve_next = '0;
                    end
                end else if (bus.iREN) begin
                    w_state_next  = S_IACC;
                    w_starve_next = '0;
                end
            end

            S_IACC: begin
                if (!bus.iREN) begin
                    // Requester withdrew: strobes already gated off, no completion.
                    w_state_next = S_IDLE;
                end else begin
                    bus.ramREN  = 1'b1;
                    bus.ramaddr = bus.iaddr;
                    if (bus.ramready) begin
                        bus.iwait    = 1'b0;
                        bus.iload    = bus.ramload;
                        w_state_next = S_DONE;
                    end else if (w_wd_fire) begin
                        bus.iwait    = 1'b0;
                        bus.iload    = ABORT_WORD;
                        w_err_next   = 1'b1;
                        w_wd_next    = WD_MAX;
                        w_state_next = S_DONE;
                    end else begin
                        w_wd_next = r_wd_cnt + 1'b1;
                    end
                end
            end

            S_DACC: begin
                if (!w_d_req) begin
                    w_state_next = S_IDLE;
                end else if (w_sc_fail) begin
                    // A broken link means the SC fails at once, with no RAM access.
                    bus.dwait    = 1'b0;
                    bus.dload    = 32'd0;
                    w_state_next = S_DONE;
                end else begin
                    bus.ramaddr  = bus.daddr;
                    bus.ramWEN   = w_d_write;
                    bus.ramREN   = w_d_read;
                    bus.ramstore = bus.dstore;
                    if (bus.ramready) begin
                        bus.dwait    = 1'b0;
                        bus.dload    = w_d_write ? 32'd0 : bus.ramload;
                        w_state_next = S_DONE;
`ifdef MEM_ARB_LLSC_EN
                        if (w_sc_ok) begin
                            bus.dload         = 32'd1;
                            w_link_valid_next = 1'b0;
                        end else if (w_plain_wr && (r_link_addr == bus.daddr)) begin
                            w_link_valid_next = 1'b0;
                        end
                        if (w_ll) begin
                            w_link_addr_next  = bus.daddr;
                            w_link_valid_next = 1'b1;
                        end
`endif
                    end else if (w_wd_fire) begin
                        bus.dwait    = 1'b0;
                        bus.dload    = ABORT_WORD;
                        w_err_next   = 1'b1;
                        w_wd_next    = WD_MAX;
                        w_state_next = S_DONE;
                    end else begin
                        w_wd_next = r_wd_cnt + 1'b1;
                    end
                end
            end

            S_DONE: begin
                // Turnaround cycle: lets the requester drop or change its request.
                w_wd_next    = '0;
                w_state_next = S_IDLE;
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Starvation and watchdog counters
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_starve_cnt <= '0;
            r_wd_cnt     <= '0;
        end else begin
            r_starve_cnt <= w_starve_next;
            r_wd_cnt     <= w_wd_next;
        end
    end

    // Sticky abort flag, cleared only by reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_err_next;
        end
    end

`ifdef MEM_ARB_LLSC_EN
    // Load-linked reservation
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_link_valid <= 1'b0;
            r_link_addr  <= 32'd0;
        end else begin
            r_link_valid <= w_link_valid_next;
            r_link_addr  <= w_link_addr_next;
        end
    end
`endif

    assign err = r_err;

endmodule
